// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a 64-word data memory.
// Each granted access takes three cycles: grant, memory access, then an acknowledge pulse.
module data_mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic        mem_wr_enable,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic        grant_valid;
   logic        grant_port;
   logic        lat_port;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        addr_ok;

   // On a tie the port that was not served last wins, so neither port can starve.
   always_comb begin
      grant_valid = req0 | req1;
      grant_port  = 1'b0;
      if (req0 && req1) begin
         grant_port = ~last_grant;
      end else if (req1) begin
         grant_port = 1'b1;
      end
   end

   assign addr_ok = (lat_addr[1:0] == 2'b00) && (lat_addr[31:8] == 24'h0);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The memory strobe is gated with rst_n so an aborted access never writes.
   always_comb begin
      state_next     = state;
      mem_wr_enable  = 1'b0;
      mem_addr       = 32'h0;
      mem_write_data = 32'h0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            mem_addr       = lat_addr;
            mem_write_data = lat_wdata;
            mem_wr_enable  = lat_we & addr_ok & rst_n;
            state_next     = ACK;
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request fields are frozen at grant; later changes on the port are ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         lat_port   <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= 32'h0;
         lat_wdata  <= 32'h0;
      end else if (state == IDLE && grant_valid) begin
         last_grant <= grant_port;
         lat_port   <= grant_port;
         if (grant_port) begin
            lat_we    <= we1;
            lat_addr  <= addr1;
            lat_wdata <= wdata1;
         end else begin
            lat_we    <= we0;
            lat_addr  <= addr0;
            lat_wdata <= wdata0;
         end
      end
   end

   // Response registers are loaded at the end of ACCESS, so ack and err are high for the ACK cycle only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         rdata0 <= 32'h0;
         rdata1 <= 32'h0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         if (state == ACCESS) begin
            if (lat_port) begin
               ack1 <= 1'b1;
               err1 <= ~addr_ok;
               if (!addr_ok) begin
                  rdata1 <= 32'h0;
               end else if (!lat_we) begin
                  rdata1 <= mem_read_data;
               end
            end else begin
               ack0 <= 1'b1;
               err0 <= ~addr_ok;
               if (!addr_ok) begin
                  rdata0 <= 32'h0;
               end else if (!lat_we) begin
                  rdata0 <= mem_read_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then random
// two-port traffic compared every cycle against a transaction-level model.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        ack0, ack1, err0, err1, mem_wr_enable, busy;
   logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;
   logic        ack_v [2];

   int total = 0;
   int bad = 0;
   bit cmp_on = 1'b0;
   bit agent_en = 1'b0;
   bit raise_en = 1'b0;

   logic [31:0] env_mem [64];
   logic [31:0] model_mem [64];

   // Model state: 0 = no transaction, 1 = memory cycle, 2 = acknowledge cycle.
   int          m_phase = 0;
   int          m_port = 0;
   int          m_last = 1;
   logic        m_we = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [31:0] exp_rd [2];

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .mem_wr_enable(mem_wr_enable), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .busy(busy)
   );

   assign ack_v[0] = ack0;
   assign ack_v[1] = ack1;
   assign mem_read_data = env_mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_wr_enable) env_mem[mem_addr[7:2]] = mem_write_data;
   end

   function automatic bit addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a[31:8] == 24'h0);
   endfunction

   function automatic logic [31:0] randAddr();
      int sel;
      sel = $urandom_range(9);
      if (sel < 7) return 32'($urandom_range(7)) << 2;
      if (sel == 7) return 32'($urandom_range(255)) | 32'h1;
      if (sel == 8) return 32'h100 + (32'($urandom_range(63)) << 2);
      return $urandom;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
      req[p]   = 1'b1;
      we[p]    = w;
      addr[p]  = a;
      wdata[p] = d;
   endtask

   task automatic dropReq(input int p);
      req[p] = 1'b0;
   endtask

   // Transaction-level reference: arbitrate, freeze the request, apply it one cycle later.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0;
         m_last  = 1;
         m_we    = 1'b0;
         m_addr  = 32'h0;
         m_wdata = 32'h0;
         exp_rd[0] = 32'h0;
         exp_rd[1] = 32'h0;
      end else if (m_phase == 0) begin
         if (req[0] || req[1]) begin
            if (req[0] && req[1]) m_port = 1 - m_last;
            else m_port = req[0] ? 0 : 1;
            m_last  = m_port;
            m_we    = we[m_port];
            m_addr  = addr[m_port];
            m_wdata = wdata[m_port];
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!addr_ok(m_addr)) exp_rd[m_port] = 32'h0;
         else if (m_we) model_mem[m_addr[7:2]] = m_wdata;
         else exp_rd[m_port] = model_mem[m_addr[7:2]];
         m_phase = 2;
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         checkOutput("busy", 32'(busy), 32'(m_phase != 0));
         checkOutput("mem_wr_enable", 32'(mem_wr_enable),
                     32'(rst_n && m_phase == 1 && m_we && addr_ok(m_addr)));
         checkOutput("mem_addr", mem_addr, (m_phase == 1) ? m_addr : 32'h0);
         checkOutput("mem_write_data", mem_write_data, (m_phase == 1) ? m_wdata : 32'h0);
         checkOutput("ack0", 32'(ack0), 32'(m_phase == 2 && m_port == 0));
         checkOutput("ack1", 32'(ack1), 32'(m_phase == 2 && m_port == 1));
         checkOutput("err0", 32'(err0), 32'(m_phase == 2 && m_port == 0 && !addr_ok(m_addr)));
         checkOutput("err1", 32'(err1), 32'(m_phase == 2 && m_port == 1 && !addr_ok(m_addr)));
         checkOutput("rdata0", rdata0, exp_rd[0]);
         checkOutput("rdata1", rdata1, exp_rd[1]);
      end
   end

   // Random requester: holds req until ack, then drops it; scrambles its inputs while granted.
   task automatic agent(input int p);
      forever begin
         @(negedge clk);
         if (agent_en) begin
            if (req[p] && ack_v[p]) begin
               #1 dropReq(p);
            end else if (req[p] && m_phase != 0 && m_port == p) begin
               #1;
               we[p]    = 1'($urandom_range(1));
               addr[p]  = randAddr();
               wdata[p] = $urandom;
            end else if (!req[p] && raise_en && $urandom_range(2) == 0) begin
               #1 applyStimulus(p, 1'($urandom_range(1)), randAddr(), $urandom);
            end
         end
      end
   endtask

   initial agent(0);
   initial agent(1);

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] simulation hung");
   end

   initial begin
      int n;
      int w;
      bit drained;
      for (int i = 0; i < 64; i++) begin
         env_mem[i]   = 32'h0;
         model_mem[i] = 32'h0;
      end
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0;
      end

      @(negedge clk);
      cmp_on = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_ack", 32'({ack0, ack1}), 32'h0);
      checkOutput("reset_rdata0", rdata0, 32'h0);
      checkOutput("reset_wr_en", 32'(mem_wr_enable), 32'h0);

      // Single write granted in the first cycle out of reset.
      #1 rst_n = 1'b1;
      applyStimulus(1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("wr_en_cycle2", 32'(mem_wr_enable), 32'h1);
      checkOutput("wr_addr_cycle2", mem_addr, 32'h10);
      checkOutput("wr_data_cycle2", mem_write_data, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("ack1_cycle3", 32'(ack1), 32'h1);
      checkOutput("err1_cycle3", 32'(err1), 32'h0);
      #1 dropReq(1);
      @(negedge clk);
      checkOutput("idle_after_write", 32'(busy), 32'h0);

      // Read-back on port 0.
      #1 applyStimulus(0, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("readback_ack0", 32'(ack0), 32'h1);
      checkOutput("readback_rdata0", rdata0, 32'hDEADBEEF);
      checkOutput("readback_err0", 32'(err0), 32'h0);
      #1 dropReq(0);
      @(negedge clk);

      // Contention after reset: strict 0,1,0,1 alternation every 3 cycles.
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(0, 1'b0, 32'h10, 32'h0);
      applyStimulus(1, 1'b0, 32'h10, 32'h0);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         do begin
            @(negedge clk);
            n++;
            w++;
         end while (!(ack0 || ack1) && w < 6);
         checkOutput("contention_port", 32'(ack1), 32'(k % 2));
         checkOutput("contention_cycle", n, 2 + 3 * k);
      end
      #1 dropReq(0);
      dropReq(1);
      @(negedge clk);

      // Invalid addresses: out of range, then misaligned.
      #1 applyStimulus(0, 1'b1, 32'h100, 32'h55AA55AA);
      @(negedge clk);
      checkOutput("bad_range_wr_en", 32'(mem_wr_enable), 32'h0);
      @(negedge clk);
      checkOutput("bad_range_err0", 32'({ack0, err0}), 32'h3);
      checkOutput("bad_range_rdata0", rdata0, 32'h0);
      #1 dropReq(0);
      @(negedge clk);
      #1 applyStimulus(1, 1'b1, 32'h12, 32'h00000001);
      @(negedge clk);
      checkOutput("misaligned_wr_en", 32'(mem_wr_enable), 32'h0);
      @(negedge clk);
      checkOutput("misaligned_err1", 32'({ack1, err1}), 32'h3);
      checkOutput("misaligned_rdata1", rdata1, 32'h0);
      #1 dropReq(1);
      @(negedge clk);

      // Reset during the memory cycle of a write; the held request is served afterwards.
      #1 applyStimulus(1, 1'b1, 32'h20, 32'h12345678);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_wr_en", 32'(mem_wr_enable), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      checkOutput("abort_ack1", 32'(ack1), 32'h0);
      @(negedge clk);
      checkOutput("retry_wr_en", 32'(mem_wr_enable), 32'h1);
      checkOutput("retry_addr", mem_addr, 32'h20);
      @(negedge clk);
      checkOutput("retry_ack1", 32'(ack1), 32'h1);
      #1 dropReq(1);
      @(negedge clk);

      // Inputs changed one cycle after grant must not affect the access.
      #1 applyStimulus(0, 1'b1, 32'h20, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      addr[0]  = 32'h24;
      wdata[0] = 32'h0BADBEEF;
      we[0]    = 1'b0;
      @(negedge clk);
      checkOutput("hold_addr", mem_addr, 32'h20);
      checkOutput("hold_data", mem_write_data, 32'hCAFEF00D);
      @(negedge clk);
      #1 dropReq(0);
      @(negedge clk);
      #1 applyStimulus(0, 1'b0, 32'h24, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("hold_untouched_0x24", rdata0, 32'h0);
      #1 dropReq(0);
      @(negedge clk);
      #1 applyStimulus(1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("hold_written_0x20", rdata1, 32'hCAFEF00D);
      #1 dropReq(1);
      @(negedge clk);

      // Random traffic with occasional resets.
      #1;
      agent_en = 1'b1;
      raise_en = 1'b1;
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(299) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      raise_en = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 40 && !drained; i++) begin
         @(negedge clk);
         drained = !req[0] && !req[1] && !busy;
      end
      checkOutput("drain", 32'(drained), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters: none; memory depth fixed at 64 words (32-bit), byte address 0x00-0xFC valid.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req0 / req1  in  1  access request, port 0 (pipeline MEM stage) / port 1 (debug loader); held high until ack.
REQ-005 we0 / we1  in  1  1 = write, 0 = read; valid while req high.
REQ-006 addr0 / addr1  in  32  byte address; valid while req high.
REQ-007 wdata0 / wdata1  in  32  write data; valid while req high.
REQ-008 ack0 / ack1  out  1  one-cycle completion pulse.
REQ-009 rdata0 / rdata1  out  32  read result, valid in ack cycle, held until next ack on that port.
REQ-010 err0 / err1  out  1  access rejected; valid only in ack cycle.
REQ-011 mem_wr_enable  out  1  write strobe to the data memory.
REQ-012 mem_addr  out  32  byte address to the data memory.
REQ-013 mem_write_data  out  32  write data to the data memory.
REQ-014 mem_read_data  in  32  combinational read data from the data memory (word at mem_addr[31:2]).
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, ACCESS, ACK; one transaction = exactly 3 cycles; max throughput 1 transaction per 3 cycles.
REQ-017 IDLE: if no req, stay IDLE; if exactly one req, grant it; if both, grant port != last_grant (round-robin); go ACCESS.
REQ-018 On grant, latch granted port's we, addr, wdata and port id into internal registers; update last_grant.
REQ-019 ACCESS: mem_addr = latched addr; mem_write_data = latched wdata; mem_wr_enable = latched we AND address valid; capture mem_read_data into rdata of granted port on read with valid address; go ACK.
REQ-020 Address valid iff addr[1:0] == 0 and addr[31:8] == 0; invalid -> no write, rdata of that port = 0, err = 1.
REQ-021 ACK: ack of granted port = 1 for this cycle only, err per REQ-020; other port ack = 0; go IDLE.
REQ-022 Outside ACCESS: mem_wr_enable = 0, mem_addr = 0, mem_write_data = 0.
REQ-023 Requester lowers req in cycle after ack; a req still high in the IDLE after ack is a new request.
REQ-024 Request arriving on the non-granted port during ACCESS/ACK waits; served next IDLE (round-robin guarantees it wins over the port just served).
REQ-025 Changes to addr/we/wdata after grant have no effect on the current transaction.
REQ-026 Read of a word written by the previous transaction returns the new value (write lands at end of ACCESS).

Reset
REQ-027 While rst_n = 0 at a rising edge: state <= IDLE, last_grant <= 1 (port 0 wins first tie), ack0/ack1/err0/err1 <= 0, rdata0/rdata1 <= 0, latched registers <= 0.
REQ-028 mem_wr_enable SHALL be 0 in any cycle rst_n = 0, including reset asserted mid-ACCESS; aborted transaction produces no ack.
REQ-029 First grant possible in the first cycle with rst_n = 1.

Verification
REQ-030 Single write: req1=1, we1=1, addr1=0x10, wdata1=0xDEADBEEF -> mem_wr_enable=1 with mem_addr=0x10 in cycle 2, ack1=1 err1=0 in cycle 3.
REQ-031 Read-back: port 0 read addr 0x10 after REQ-030 -> ack0 with rdata0=0xDEADBEEF, err0=0.
REQ-032 Contention: req0 and req1 raised same cycle after reset -> port 0 acked first, port 1 acked 3 cycles later; repeat with both held -> strict alternation 0,1,0,1.
REQ-033 Invalid address: write addr=0x100 and addr=0x12 -> mem_wr_enable stays 0, ack with err=1, rdata=0.
REQ-034 Reset mid-op: rst_n=0 during ACCESS of a write -> no mem_wr_enable, no ack, busy=0 next cycle; pending req served after rst_n=1.
REQ-035 Hold-after-grant: change addr0 from 0x20 to 0x24 one cycle after grant -> access uses 0x20.
